// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR host-side master: bus widths, address fields,
// default hold time and the master FSM encoding.
package ddr_pkg;

    localparam int DDR_ADDR_W   = 8;
    localparam int DDR_DATA_W   = 64;
    localparam int DDR_ROW_MSB  = 7;
    localparam int DDR_ROW_LSB  = 4;
    localparam int DDR_HOLD_CYC = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } ddr_state_t;

    // Flipping the low row bit guarantees a row miss against the given address.
    function automatic logic [DDR_ADDR_W-1:0] row_miss_addr(input logic [DDR_ADDR_W-1:0] a);
        logic [DDR_ADDR_W-1:0] r;
        r = a;
        r[DDR_ROW_LSB] = ~a[DDR_ROW_LSB];
        return r;
    endfunction

endpackage

// File: rtl/ddr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/count.
// A push on a full FIFO is taken when a pop happens in the same cycle.
module ddr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ddr_host_master.sv
// Host-side master for the DDR controller: queues user commands, issues them one
// at a time with a fixed hold gap, and tags read returns back to their addresses.
module ddr_host_master
    import ddr_pkg::*;
#(
    parameter int HOLD_CYC = DDR_HOLD_CYC,
    parameter int DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [DDR_ADDR_W-1:0] cmd_addr,
    input  logic [DDR_DATA_W-1:0] cmd_wdata,
    output logic                  req,
    output logic                  write,
    output logic [DDR_ADDR_W-1:0] addr,
    output logic [DDR_DATA_W-1:0] wdata,
    input  logic                  ack,
    input  logic                  rd_en,
    input  logic [DDR_DATA_W-1:0] rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DDR_ADDR_W-1:0] rsp_addr,
    output logic [DDR_DATA_W-1:0] rsp_data,
    output logic                  busy,
    output logic [2:0]            rd_outstanding,
    output logic                  err_overflow,
    output ddr_state_t            fsm_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CMD_W = 1 + DDR_ADDR_W + DDR_DATA_W;
    localparam int RSP_W = DDR_ADDR_W + DDR_DATA_W;

    ddr_state_t            state;
    logic [3:0]            hold_cnt;
    logic [CMD_W-1:0]      cmd_head;
    logic                  cmd_full, cmd_empty;
    logic [CNT_W-1:0]      cmd_count;
    logic [DDR_ADDR_W-1:0] tag_head;
    logic                  tag_full, tag_empty;
    logic [CNT_W-1:0]      tag_count;
    logic [RSP_W-1:0]      rsp_head;
    logic                  rsp_full, rsp_empty;
    logic [CNT_W-1:0]      rsp_count;
    logic                  head_write;
    logic [DDR_ADDR_W-1:0] head_addr;
    logic [DDR_DATA_W-1:0] head_wdata;
    logic                  accept, rd_credit, can_issue, rd_take, hold_done;

    assign {head_write, head_addr, head_wdata} = cmd_head;
    assign accept    = req & ack;
    // Reads in flight plus parked responses must leave room in the response queue.
    assign rd_credit = ((CNT_W+1)'(tag_count) + (CNT_W+1)'(rsp_count)) < (CNT_W+1)'(DEPTH);
    assign can_issue = ~cmd_empty & (head_write | rd_credit);
    assign rd_take   = rd_en & ~tag_empty & ~rsp_full;
    assign hold_done = (hold_cnt == 4'(HOLD_CYC - 1));

    assign cmd_ready      = ~cmd_full;
    assign rsp_valid      = ~rsp_empty;
    assign {rsp_addr, rsp_data} = rsp_head;
    assign rd_outstanding = 3'(tag_count);
    assign fsm_state      = state;
    assign busy = (cmd_count != '0) | (tag_count != '0) | (rsp_count != '0) | (state != ST_IDLE);

    ddr_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_q (
        .clk(clk), .rstn(rstn),
        .push(cmd_valid & cmd_ready), .wdata({cmd_write, cmd_addr, cmd_wdata}),
        .pop(accept), .rdata(cmd_head),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    ddr_sync_fifo #(.WIDTH(DDR_ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk(clk), .rstn(rstn),
        .push(accept & ~write & ~tag_full), .wdata(addr),
        .pop(rd_take), .rdata(tag_head),
        .full(tag_full), .empty(tag_empty), .count(tag_count)
    );

    ddr_sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_q (
        .clk(clk), .rstn(rstn),
        .push(rd_take), .wdata({tag_head, rdata}),
        .pop(rsp_valid & rsp_ready), .rdata(rsp_head),
        .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            req          <= 1'b0;
            write        <= 1'b0;
            addr         <= row_miss_addr('0);
            wdata        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (rd_en && (tag_empty || rsp_full)) err_overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!cmd_empty) begin
                        state <= ST_REQ;
                        req   <= can_issue;
                        write <= head_write;
                        addr  <= head_addr;
                        wdata <= head_wdata;
                    end
                end
                ST_REQ: begin
                    if (accept) begin
                        state    <= ST_HOLD;
                        req      <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        req   <= can_issue;
                        write <= head_write;
                        addr  <= head_addr;
                        wdata <= head_wdata;
                    end
                end
                ST_HOLD: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end else if (!cmd_empty) begin
                        hold_cnt <= '0;
                        state    <= ST_REQ;
                        req      <= can_issue;
                        write    <= head_write;
                        addr     <= head_addr;
                        wdata    <= head_wdata;
                    end else begin
                        // Park on a different row so the controller closes the open one.
                        hold_cnt <= '0;
                        state    <= ST_IDLE;
                        write    <= 1'b0;
                        addr     <= row_miss_addr(addr);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr_host_master.md
DDR_HOST_MASTER -- requirements
Module: ddr_host_master

Interface
REQ-001 Parameter HOLD_CYC, default 10: cycles with req low and fields frozen after each accepted request (covers controller tRCD+1).
REQ-002 Parameter DEPTH, default 4: entries in each of the command, read-tag and response queues.
REQ-003 Clocking: reset rstn, asynchronous, active-low; clock clk.
REQ-004 clk  in  1  rising-edge clock, same clock as the DDR controller host port.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  user command handshake; a transfer occurs when both are high.
REQ-007 cmd_write, cmd_addr, cmd_wdata  in  1 / 8 / 64  command fields; addr[7:4] is the row, addr[3:0] is the column.
REQ-008 req, write, addr, wdata  out  1 / 1 / 8 / 64  drive controller i_req, i_write, i_addr, i_wdata.
REQ-009 ack  in  1  controller o_ack (combinational in the controller); acceptance = req & ack.
REQ-010 rd_en, rdata  in  1 / 64  controller read-return pulse and data.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake.
REQ-012 rsp_addr, rsp_data  out  8 / 64  address and data of the returned read.
REQ-013 busy  out  1  high when any queue is non-empty or the FSM is not in IDLE.
REQ-014 rd_outstanding  out  3  number of reads accepted by the controller and not yet returned.
REQ-015 err_overflow  out  1  sticky error flag; cleared only by reset.

Function
REQ-016 FSM states and transitions:
- IDLE -> REQ when the command queue is non-empty.
- REQ -> HOLD on acceptance.
- HOLD -> REQ after HOLD_CYC cycles if the command queue is non-empty; otherwise HOLD -> IDLE.
REQ-017 REQ state: req=1 and write/addr/wdata come from the command-queue head, held stable until acceptance.
REQ-018 On acceptance: pop the head, register its fields into the output registers, and hold them unchanged through HOLD. The controller samples write during ACT.
REQ-019 IDLE state: req=0, write=0, addr = last accepted addr XOR 8'h10 (forced row miss), so an ending WR/RD sequence precharges instead of repeating.
REQ-020 A read is not issued unless rd_outstanding plus response-queue occupancy is below DEPTH. REQ stalls with req=0 until the condition holds.
REQ-021 Read tags:
- On acceptance of a read, push addr onto the tag queue and increment rd_outstanding.
- On rd_en, pop the tag and push {tag, rdata} onto the response queue in the same cycle.
- Read responses return in issue order.
REQ-022 rd_en and read acceptance in the same cycle: rd_outstanding is unchanged, the tag queue pushes and pops, and the pop returns the older entry.
REQ-023 err_overflow is set when rd_en arrives with rd_outstanding==0 or with the response queue full. In either case the data is dropped and no counter changes.
REQ-024 cmd_ready = command queue not full. A simultaneous push and pop on a full queue is allowed.
REQ-025 Response queue is first-word-fall-through: rsp_valid = not empty, and the entry pops on rsp_valid & rsp_ready.
REQ-026 Writes produce no response.
REQ-027 The HOLD counter is 4 bits. Only the counter values needed to count HOLD_CYC cycles are used; it does not wrap.

Reset
REQ-028 Reset drives outputs and state as follows:
- FSM = IDLE; all queues empty.
- req=0, write=0, addr=8'h10, wdata=0.
- rsp_valid=0, rsp_addr=0, rsp_data=0.
- busy=0, rd_outstanding=0, err_overflow=0.
- cmd_ready=1.
REQ-029 Reset asserted mid-request or mid-HOLD aborts immediately and discards all queued and outstanding state. Returns that arrive after reset release and have no matching tag set err_overflow.

Structure
REQ-030 Shared package ddr_pkg holds: DDR_ADDR_W=8, DDR_DATA_W=64, DDR_ROW_MSB=7, DDR_ROW_LSB=4, HOLD_CYC default, and the FSM state encoding IDLE=0, REQ=1, HOLD=2.
REQ-031 One sub-module, ddr_sync_fifo (parameterised width and depth, first-word-fall-through, full/empty/count), is instantiated three times: command queue (73 bits), tag queue (8 bits), response queue (72 bits).

Verification
REQ-032 The bench connects this block to the DDR controller and DRAM model. Required scenarios:
- Write 0x1122334455667788 to addr 0x23, then read 0x23 -> rsp_addr=0x23 and rsp_data=0x1122334455667788 within 60 cycles of the read's acceptance.
- Writes to 0x31, 0x32 and 0x33 (same row) queued back-to-back -> three acceptances, req low for exactly 10 cycles after each, and no extra DRAM write at 0x33.
- Reads of 0x45 and then 0x91 (row change) -> two responses in order and a PRE between them; rd_outstanding goes 1, 2, 1, 0.
- Hold rsp_ready=0 and issue 6 reads -> only 4 are accepted; the 5th is accepted only after one rsp pop; err_overflow stays 0.
- Inject an rd_en pulse with no read outstanding -> err_overflow=1, stays 1, and no response is produced.
- Assert rstn low during HOLD of a read -> all outputs return to reset values within 1 cycle and cmd_ready=1.
